operand_fetch_seq: RTL and testbench
====================================

OPERAND_FETCH_SEQ -- requirements
Module: operand_fetch_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address/PC/EA width.
REQ-002 SHALL have parameter DATA_W, default 8, memory data width; operand width is 2*DATA_W.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 15, max wait cycles per access (used only with WAIT_TIMEOUT_EN).
REQ-004 SHALL have ports as listed, clock and reset first: clk in 1 system clock; reset in 1 asynchronous active-low reset.
REQ-005 start in 1 begin sequence; mode in 3 addressing mode; wide in 1 read 2-byte data at EA.
REQ-006 pc in ADDR_W PC at start; dp in ADDR_W-DATA_W direct-page register.
REQ-007 mem_req out 1 access request; mem_addr out ADDR_W access address; mem_ack in 1 access complete; mem_rdata in DATA_W read data.
REQ-008 pc_inc out 1 one-cycle pulse per PC-addressed byte accepted.
REQ-009 ea out ADDR_W effective address; operand out 2*DATA_W fetched value; busy out 1; done out 1 pulse; err out 1 pulse.

Function
REQ-010 Modes (package encoding): INH=0, IMM8=1, IMM16=2, DIR=3, EXT=4, REL8=5, REL16=6; 7 reserved.
REQ-011 start SHALL be sampled only in IDLE; ignored while busy=1.
REQ-012 On start, pc SHALL be captured into internal pc_q; PC fetches use mem_addr=pc_q, pc_q increments on each such ack.
REQ-013 States: IDLE, PC_HI, PC_LO, DAT_HI, DAT_LO, FIN; FIN returns to IDLE next cycle.
REQ-014 INH: IDLE->FIN, no memory access; done one cycle after start.
REQ-015 IMM8: PC_LO -> operand={0,byte}. IMM16: PC_HI, PC_LO -> operand={hi,lo}, big-endian.
REQ-016 DIR: PC_LO fetches offset; ea={dp,offset}; then data read(s) at ea.
REQ-017 EXT: PC_HI, PC_LO fetch ea hi/lo; then data read(s) at ea.
REQ-018 Data read: wide=0 -> DAT_LO only, operand={0,byte}; wide=1 -> DAT_HI at ea, DAT_LO at ea+1 (mod 2^ADDR_W).
REQ-019 REL8: ea = pc_q_after_fetch + sign-extended offset; REL16: 16-bit offset; arithmetic mod 2^ADDR_W; operand = raw offset zero-extended; no data read.
REQ-020 Handshake: mem_req and mem_addr SHALL remain stable from assertion until the cycle mem_ack=1; mem_rdata captured that cycle; next access may request the following cycle; zero or more wait states allowed.
REQ-021 mem_ack while mem_req=0 SHALL be ignored.
REQ-022 pc_inc SHALL pulse in exactly the cycle of each ack on a PC-addressed access.
REQ-023 done SHALL pulse one cycle in FIN; ea/operand valid from FIN and held until next start.
REQ-024 busy=1 in every state except IDLE.
REQ-025 Reserved mode SHALL go to FIN with err=1, no access, pc_inc never asserted.

Reset
REQ-026 reset low SHALL immediately force IDLE, mem_req=0, pc_inc=0, done=0, err=0, busy=0, ea=0, operand=0, pc_q=0, independent of clk.
REQ-027 Reset mid-access SHALL abandon the access; no done/err pulse after release.

Configuration
REQ-028 Macro OPFETCH_WAIT_TIMEOUT_EN defined: per-access wait counter; if mem_ack absent for TIMEOUT_CYC cycles with mem_req=1, drop mem_req, go to FIN, pulse done and err together; ea/operand hold partial values.
REQ-029 Macro undefined: no counter, err asserted only for reserved mode, waits indefinitely.

Structure
REQ-030 Shared package opfetch_pkg SHALL hold mode encodings, state enum, and operand-width constant.
REQ-031 Timeout counter SHALL be sub-module opfetch_timer (clear on ack/new request, expire flag), instantiated only under the macro.

Verification
REQ-032 IMM16, pc=0x1000, mem[0x1000]=0x12, mem[0x1001]=0x34, no waits -> operand=0x1234, two pc_inc pulses, done 3 cycles after start.
REQ-033 DIR wide=1, dp=0x20, mem[pc]=0x40, mem[0x2040]=0xAB, mem[0x2041]=0xCD, 2 wait states each -> ea=0x2040, operand=0xABCD, one pc_inc.
REQ-034 REL8, pc=0x0100, offset 0xFE -> ea=0x00FF; REL16 pc=0xFFFE, offset 0x0003 -> ea=0x0003 (wrap).
REQ-035 EXT wide=1, ea=0xFFFF -> second read at 0x0000; start pulsed while busy -> ignored.
REQ-036 Reset asserted during DAT_LO wait -> mem_req low same cycle, no done; mode=7 -> done+err, no mem_req.
REQ-037 With OPFETCH_WAIT_TIMEOUT_EN, mem_ack never returned -> done+err after TIMEOUT_CYC cycles, mem_req deasserted.

Source files
------------

// File: rtl/opfetch_pkg.sv
// Shared encodings for the operand fetch sequencer: addressing modes, FSM states,
// operand width multiplier.
package opfetch_pkg;
  typedef enum logic [2:0] {
    M_INH   = 3'd0,
    M_IMM8  = 3'd1,
    M_IMM16 = 3'd2,
    M_DIR   = 3'd3,
    M_EXT   = 3'd4,
    M_REL8  = 3'd5,
    M_REL16 = 3'd6,
    M_RSVD  = 3'd7
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE, S_PC_HI, S_PC_LO, S_DAT_HI, S_DAT_LO, S_FIN
  } state_e;

  // operand is this many memory words wide
  localparam int OPND_MULT = 2;

  function automatic logic is_pc_state(input state_e s);
    return (s == S_PC_HI) || (s == S_PC_LO);
  endfunction
endpackage

// File: rtl/operand_fetch_seq_timer.sv
// Per-access wait-state watchdog; only instantiated when OPFETCH_WAIT_TIMEOUT_EN is defined.
module opfetch_timer #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clr,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  // cnt holds the number of un-acked request cycles already elapsed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              cnt <= '0;
    else if (!run || clr)    cnt <= '0;
    else if (!expired)       cnt <= cnt + CW'(1);
  end

  assign expired = run && !clr && (cnt == CW'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/operand_fetch_seq.sv
// Operand fetch sequencer: PC-relative instruction byte fetch, EA formation and data read.
// Optional wait-state timeout enabled by defining OPFETCH_WAIT_TIMEOUT_EN.
module operand_fetch_seq
  import opfetch_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [2:0]               mode,
  input  logic                     wide,
  input  logic [ADDR_W-1:0]        pc,
  input  logic [ADDR_W-DATA_W-1:0] dp,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_ack,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     pc_inc,
  output logic [ADDR_W-1:0]        ea,
  output logic [OPND_MULT*DATA_W-1:0] operand,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);
  localparam int OPW = OPND_MULT * DATA_W;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  state_e              state;
  mode_e               mode_q;
  logic                wide_q;
  logic [ADDR_W-1:0]   pc_q;
  logic                ack;
  logic [ADDR_W-1:0]   pc_nxt;
  logic [OPW-1:0]      word;
  logic [ADDR_W-1:0]   ea_fetch;
  logic [ADDR_W-1:0]   rel8, rel16;

  assign ack      = mem_ack & mem_req;
  assign pc_inc   = ack & is_pc_state(state);
  assign pc_nxt   = pc_q + ADDR_W'(1);
  assign word     = {operand[OPW-1:DATA_W], mem_rdata};
  assign ea_fetch = (mode_q == M_DIR) ? {dp, mem_rdata} : ADDR_W'(word);
  // size casts of signed values sign-extend to ADDR_W
  assign rel8     = ADDR_W'($signed(mem_rdata));
  assign rel16    = ADDR_W'($signed(word));

`ifdef OPFETCH_WAIT_TIMEOUT_EN
  logic tmo_expired;

  opfetch_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .run     (mem_req),
    .clr     (ack),
    .expired (tmo_expired)
  );
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      mode_q   <= M_INH;
      wide_q   <= 1'b0;
      pc_q     <= '0;
      ea       <= '0;
      operand  <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          pc_q     <= pc;
          mode_q   <= mode_e'(mode);
          wide_q   <= wide;
          ea       <= '0;
          operand  <= '0;
          busy     <= 1'b1;
          mem_addr <= pc;
          case (mode_e'(mode))
            M_IMM8, M_DIR, M_REL8:    begin state <= S_PC_LO; mem_req <= 1'b1; end
            M_IMM16, M_EXT, M_REL16:  begin state <= S_PC_HI; mem_req <= 1'b1; end
            M_RSVD:                   begin state <= S_FIN; done <= 1'b1; err <= 1'b1; end
            default:                  begin state <= S_FIN; done <= 1'b1; end
          endcase
        end
        S_FIN: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
`ifdef OPFETCH_WAIT_TIMEOUT_EN
          if (tmo_expired) begin
            mem_req <= 1'b0;
            state   <= S_FIN;
            done    <= 1'b1;
            err     <= 1'b1;
          end else if (ack) begin
`else
          if (ack) begin
`endif
            case (state)
              S_PC_HI: begin
                operand[OPW-1:DATA_W] <= mem_rdata;
                pc_q     <= pc_nxt;
                mem_addr <= pc_nxt;
                state    <= S_PC_LO;
              end
              S_PC_LO: begin
                pc_q <= pc_nxt;
                case (mode_q)
                  M_DIR, M_EXT: begin
                    ea       <= ea_fetch;
                    mem_addr <= ea_fetch;
                    operand  <= '0;
                    state    <= wide_q ? S_DAT_HI : S_DAT_LO;
                  end
                  M_REL8: begin
                    ea <= pc_nxt + rel8;
                    operand <= word; mem_req <= 1'b0; state <= S_FIN; done <= 1'b1;
                  end
                  M_REL16: begin
                    ea <= pc_nxt + rel16;
                    operand <= word; mem_req <= 1'b0; state <= S_FIN; done <= 1'b1;
                  end
                  default: begin
                    operand <= word; mem_req <= 1'b0; state <= S_FIN; done <= 1'b1;
                  end
                endcase
              end
              S_DAT_HI: begin
                operand[OPW-1:DATA_W] <= mem_rdata;
                mem_addr <= ea + ADDR_W'(1);
                state    <= S_DAT_LO;
              end
              S_DAT_LO: begin
                operand[DATA_W-1:0] <= mem_rdata;
                mem_req <= 1'b0;
                state   <= S_FIN;
                done    <= 1'b1;
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_operand_fetch_seq.sv
// Directed vector bench for operand_fetch_seq with a wait-state memory responder.
module tb_operand_fetch_seq;
  import opfetch_pkg::*;
  localparam int AW = 16, DW = 8, TMO = 15;

  logic            clk = 1'b0, reset = 1'b1;
  logic            start = 1'b0, wide = 1'b0, mem_ack = 1'b0;
  logic [2:0]      mode = 3'd0;
  logic [AW-1:0]   pc = '0, mem_addr, ea;
  logic [AW-DW-1:0] dp = '0;
  logic [DW-1:0]   mem_rdata = '0;
  logic [2*DW-1:0] operand;
  logic            mem_req, pc_inc, busy, done, err;

  always #5 clk = ~clk;

  operand_fetch_seq #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .wide(wide), .pc(pc), .dp(dp),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .pc_inc(pc_inc), .ea(ea), .operand(operand), .busy(busy), .done(done), .err(err)
  );

  logic [7:0] mem [65536];
  int   waits = 0;
  logic force_ack = 1'b0;
  int   wcnt = 0;

  // responder: ack after `waits` stall cycles
  always @(negedge clk) begin
    if (mem_req) begin
      if (wcnt >= waits) begin
        mem_ack = 1'b1; mem_rdata = mem[mem_addr]; wcnt = 0;
      end else begin
        mem_ack = force_ack; mem_rdata = 8'hEE; wcnt++;
      end
    end else begin
      mem_ack = force_ack; mem_rdata = 8'hEE; wcnt = 0;
    end
  end

  int pcinc_tot = 0, req_tot = 0, stab_err = 0, done_tot = 0, err_tot = 0;
  logic pend = 1'b0;
  logic [AW-1:0] held = '0;
  always @(posedge clk) begin
    if (pc_inc) pcinc_tot++;
    if (done) done_tot++;
    if (err) err_tot++;
    if (mem_req) begin
      req_tot++;
      if (pend && mem_addr != held) stab_err++;
      held = mem_addr;
      pend = !mem_ack;
    end else pend = 1'b0;
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  mode;
    logic        wide;
    logic [15:0] pc;
    logic [7:0]  dp;
    int          waits;
    logic [63:0] ma;
    logic [31:0] md;
    logic [15:0] x_ea;
    logic [15:0] x_op;
    int          x_pcinc;
    int          x_acc;
    logic        x_err;
    int          poke;
  } vec_t;

  vec_t vecs[11];

  task automatic run_vec(input vec_t v, input int idx);
    int cyc, p0, r0;
    string t;
    t = $sformatf("v%0d", idx);
    for (int k = 0; k < 4; k++) mem[v.ma[16*k +: 16]] = v.md[8*k +: 8];
    waits = v.waits;
    @(negedge clk);
    mode = v.mode; wide = v.wide; pc = v.pc; dp = v.dp; start = 1'b1;
    p0 = pcinc_tot; r0 = req_tot;
    @(negedge clk);
    start = 1'b0; cyc = 1;
    while (!done && cyc < 300) begin
      if (cyc == v.poke) begin start = 1'b1; mode = 3'd0; pc = 16'hDEAD; end
      else start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({t, " latency"}, cyc, 1 + v.x_acc * (v.waits + 1));
    chk({t, " ea"}, {16'h0, ea}, {16'h0, v.x_ea});
    chk({t, " operand"}, {16'h0, operand}, {16'h0, v.x_op});
    chk({t, " err"}, {31'h0, err}, {31'h0, v.x_err});
    chk({t, " busy_fin"}, {31'h0, busy}, 32'd1);
    chk({t, " pc_inc_cnt"}, pcinc_tot - p0, v.x_pcinc);
    chk({t, " req_cycles"}, req_tot - r0, v.x_acc * (v.waits + 1));
    @(negedge clk);
    chk({t, " done_pulse"}, {31'h0, done}, 32'd0);
    chk({t, " busy_idle"}, {31'h0, busy}, 32'd0);
  endtask

  initial begin
    int cyc, d0, e0, p0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    //          mode     w  pc        dp     wt  mem addrs (a3..a0)                                  mem data (d3..d0)                x_ea      x_op     pci acc err poke
    vecs[0]  = '{M_IMM16, 0, 16'h1000, 8'h00, 0, {16'h1001, 16'h1001, 16'h1001, 16'h1000}, {8'h34, 8'h34, 8'h34, 8'h12}, 16'h0000, 16'h1234, 2, 2, 1'b0, 0};
    vecs[1]  = '{M_IMM8,  0, 16'h2000, 8'h00, 1, {16'h2000, 16'h2000, 16'h2000, 16'h2000}, {8'h5A, 8'h5A, 8'h5A, 8'h5A}, 16'h0000, 16'h005A, 1, 1, 1'b0, 0};
    vecs[2]  = '{M_INH,   0, 16'h2100, 8'h00, 0, {16'h2100, 16'h2100, 16'h2100, 16'h2100}, {8'h99, 8'h99, 8'h99, 8'h99}, 16'h0000, 16'h0000, 0, 0, 1'b0, 0};
    vecs[3]  = '{M_DIR,   1, 16'h3000, 8'h20, 2, {16'h2041, 16'h2041, 16'h2040, 16'h3000}, {8'hCD, 8'hCD, 8'hAB, 8'h40}, 16'h2040, 16'hABCD, 1, 3, 1'b0, 0};
    vecs[4]  = '{M_DIR,   0, 16'h3100, 8'h20, 1, {16'h2080, 16'h2080, 16'h2080, 16'h3100}, {8'h77, 8'h77, 8'h77, 8'h80}, 16'h2080, 16'h0077, 1, 2, 1'b0, 0};
    vecs[5]  = '{M_EXT,   1, 16'h4000, 8'h00, 0, {16'h0000, 16'hFFFF, 16'h4001, 16'h4000}, {8'h22, 8'h11, 8'hFF, 8'hFF}, 16'hFFFF, 16'h1122, 2, 4, 1'b0, 2};
    vecs[6]  = '{M_EXT,   0, 16'h4100, 8'h00, 1, {16'h1234, 16'h1234, 16'h4101, 16'h4100}, {8'h9C, 8'h9C, 8'h34, 8'h12}, 16'h1234, 16'h009C, 2, 3, 1'b0, 3};
    vecs[7]  = '{M_REL8,  0, 16'h0100, 8'h00, 0, {16'h0100, 16'h0100, 16'h0100, 16'h0100}, {8'hFE, 8'hFE, 8'hFE, 8'hFE}, 16'h00FF, 16'h00FE, 1, 1, 1'b0, 0};
    vecs[8]  = '{M_REL8,  0, 16'h0200, 8'h00, 2, {16'h0200, 16'h0200, 16'h0200, 16'h0200}, {8'h10, 8'h10, 8'h10, 8'h10}, 16'h0211, 16'h0010, 1, 1, 1'b0, 0};
    vecs[9]  = '{M_REL16, 0, 16'hFFFE, 8'h00, 1, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE}, {8'h03, 8'h03, 8'h03, 8'h00}, 16'h0003, 16'h0003, 2, 2, 1'b0, 0};
    vecs[10] = '{M_RSVD,  0, 16'h7000, 8'h00, 0, {16'h7000, 16'h7000, 16'h7000, 16'h7000}, {8'h55, 8'h55, 8'h55, 8'h55}, 16'h0000, 16'h0000, 0, 0, 1'b1, 0};

    // reset state
    #1 reset = 1'b0;
    #1;
    repeat (2) @(negedge clk);
    chk("rst mem_req", {31'h0, mem_req}, 32'd0);
    chk("rst busy", {31'h0, busy}, 32'd0);
    chk("rst done_err_pcinc", {29'h0, done, err, pc_inc}, 32'd0);
    chk("rst ea_operand", {ea, operand}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // stray acks while idle must not start anything
    p0 = pcinc_tot; d0 = done_tot;
    @(negedge clk); force_ack = 1'b1;
    repeat (3) @(negedge clk);
    force_ack = 1'b0;
    chk("stray_ack busy", {31'h0, busy}, 32'd0);
    chk("stray_ack pc_inc", pcinc_tot - p0, 0);
    chk("stray_ack done", done_tot - d0, 0);

    // reset during a DAT_LO wait
    mem[16'h5000] = 8'h10;
    waits = 5;
    @(negedge clk);
    mode = M_DIR; wide = 1'b0; pc = 16'h5000; dp = 8'h20; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 1;
    while (cyc < 9) begin @(negedge clk); cyc++; end
    chk("midrst req_before", {31'h0, mem_req}, 32'd1);
    chk("midrst addr_before", {16'h0, mem_addr}, 32'h2010);
    reset = 1'b0;
    #1;
    chk("midrst req_now", {31'h0, mem_req}, 32'd0);
    chk("midrst busy_now", {31'h0, busy}, 32'd0);
    chk("midrst ea_operand", {ea, operand}, 32'd0);
    d0 = done_tot; e0 = err_tot;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst no_done", done_tot - d0, 0);
    chk("midrst no_err", err_tot - e0, 0);
    chk("midrst busy_after", {31'h0, busy}, 32'd0);

    // the bench keeps working after reset
    run_vec(vecs[0], 11);

`ifdef OPFETCH_WAIT_TIMEOUT_EN
    waits = 100000;
    p0 = req_tot;
    @(negedge clk);
    mode = M_IMM8; pc = 16'h6000; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 1;
    while (!done && cyc < 100) begin @(negedge clk); cyc++; end
    chk("tmo latency", cyc, TMO + 1);
    chk("tmo err", {31'h0, err}, 32'd1);
    chk("tmo req_dropped", {31'h0, mem_req}, 32'd0);
    chk("tmo req_cycles", req_tot - p0, TMO);
    @(negedge clk);
    chk("tmo done_pulse", {31'h0, done}, 32'd0);
    waits = 0;
`endif

    chk("addr_stability", stab_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
